// File: rtl/spi_pkg.sv
// Shared types and framing constants for the arbitrated SPI write master.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP
  } state_t;

  localparam int SPI_DATA_W        = 8;
  localparam int SPI_LEAD_BITS     = 1;
  localparam int SPI_TRAIL_BITS    = 1;
  localparam int SPI_FRAME_PERIODS = SPI_LEAD_BITS + SPI_DATA_W + SPI_TRAIL_BITS;
  localparam int PERIOD_W          = $clog2(SPI_FRAME_PERIODS);

  // Counter width that stays at least one bit when the count range collapses to 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // NOTE: every variable written here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, pointer} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin shared SPI write master: grants one requester, sends a lead-in, 8 data bits
// MSB first and a trailer, then holds cs high for a fixed gap before re-arbitrating.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CLK_DIV  = 2,
  parameter int GAP_CLKS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [8*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]      ack,
  output logic                    busy,
  output logic [2:0]              active_id,
  output logic                    sclk,
  output logic                    mosi,
  output logic                    cs
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int DIV_W = cnt_w(CLK_DIV);
  localparam int GAP_W = cnt_w(GAP_CLKS);

  localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(GAP_CLKS - 1);
  localparam logic [PERIOD_W-1:0] LAST_PERIOD = PERIOD_W'(SPI_FRAME_PERIODS - 1);
  localparam logic [PERIOD_W-1:0] DATA_FIRST  = PERIOD_W'(SPI_LEAD_BITS);
  localparam logic [PERIOD_W-1:0] DATA_END    = PERIOD_W'(SPI_LEAD_BITS + SPI_DATA_W);

  state_t                  state, state_next;
  logic [PTR_W-1:0]        ptr, ptr_next;
  logic [SPI_DATA_W-1:0]   shreg, shreg_next;
  logic [DIV_W-1:0]        div_cnt, div_next;
  logic [PERIOD_W-1:0]     period, period_next;
  logic [GAP_W-1:0]        gap_cnt, gap_next;
  logic [NUM_REQ-1:0]      ack_next;
  logic                    busy_next, sclk_next, mosi_next, cs_next;
  logic [2:0]              active_id_next;

  logic [NUM_REQ-1:0]      grant;
  logic [PTR_W-1:0]        grant_idx;
  logic [SPI_DATA_W-1:0]   grant_byte;

  spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (req),
    .pointer   (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    grant_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_byte = grant_byte | (req_data[8*i +: 8] & {SPI_DATA_W{grant[i]}});
    end
  end

  // NOTE: combinational logic uses blocking '=', the register process uses non-blocking '<=' only.
  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    shreg_next     = shreg;
    div_next       = div_cnt;
    period_next    = period;
    gap_next       = gap_cnt;
    ack_next       = '0;
    busy_next      = busy;
    sclk_next      = sclk;
    mosi_next      = mosi;
    cs_next        = cs;
    active_id_next = active_id;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_next     = FRAME;
          shreg_next     = grant_byte;
          active_id_next = 3'(grant_idx);
          busy_next      = 1'b1;
          cs_next        = 1'b0;
          div_next       = '0;
          period_next    = '0;
        end
      end

      FRAME: begin
        if (div_cnt == DIV_LAST) begin
          div_next = '0;
          if (!sclk) begin
            // Rising sclk: the only point mosi moves, so it is settled for the slave's falling-edge sample.
            sclk_next = 1'b1;
            if (period >= DATA_FIRST && period < DATA_END) begin
              mosi_next  = shreg[SPI_DATA_W-1];
              shreg_next = shreg << 1;
            end else begin
              mosi_next = 1'b0;
            end
          end else begin
            sclk_next = 1'b0;
            if (period == LAST_PERIOD) begin
              cs_next    = 1'b1;
              mosi_next  = 1'b0;
              ack_next   = NUM_REQ'(1) << active_id;
              ptr_next   = (active_id == 3'(NUM_REQ - 1)) ? '0 : PTR_W'(active_id + 3'd1);
              state_next = GAP;
              gap_next   = '0;
            end else begin
              period_next = period + 1'b1;
            end
          end
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = IDLE;
          busy_next  = 1'b0;
        end else begin
          gap_next = gap_cnt + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // NOTE: the data shift register is plain flops, so it is reset with everything else for deterministic state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      shreg     <= '0;
      div_cnt   <= '0;
      period    <= '0;
      gap_cnt   <= '0;
      ack       <= '0;
      busy      <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      cs        <= 1'b1;
      active_id <= '0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      shreg     <= shreg_next;
      div_cnt   <= div_next;
      period    <= period_next;
      gap_cnt   <= gap_next;
      ack       <= ack_next;
      busy      <= busy_next;
      sclk      <= sclk_next;
      mosi      <= mosi_next;
      cs        <= cs_next;
      active_id <= active_id_next;
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: two instances (CLK_DIV=2 and 1) checked every cycle against a
// timeline model, plus directed frame captures with hand-computed expectations.
module tb_spi_master_arbiter;

  localparam int N   = 4;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0][N-1:0]   req_v;
  logic [1:0][8*N-1:0] data_v;
  logic [1:0][N-1:0]   ack_v;
  logic [1:0][2:0]     id_v;
  logic [1:0]          busy_v, sclk_v, mosi_v, cs_v;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_master_arbiter #(.NUM_REQ(N), .CLK_DIV(2), .GAP_CLKS(GAP)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_v[0]), .req_data(data_v[0]), .ack(ack_v[0]),
    .busy(busy_v[0]), .active_id(id_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]), .cs(cs_v[0])
  );

  spi_master_arbiter #(.NUM_REQ(N), .CLK_DIV(1), .GAP_CLKS(GAP)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_v[1]), .req_data(data_v[1]), .ack(ack_v[1]),
    .busy(busy_v[1]), .active_id(id_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]), .cs(cs_v[1])
  );

  function automatic int div_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Model: a frame is a timeline measured from the grant edge; everything follows from the offset.
  int          cyc = 0;
  bit          m_idle [2] = '{1'b1, 1'b1};
  int          m_g    [2] = '{0, 0};
  int          m_id   [2] = '{0, 0};
  int          m_ptr  [2] = '{0, 0};
  logic [7:0]  m_byte [2] = '{8'h00, 8'h00};

  always @(posedge clk or negedge rst_n) begin
    int i;
    int t;
    if (!rst_n) begin
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
        m_idle[k] = 1'b1; m_g[k] = 0; m_id[k] = 0; m_ptr[k] = 0;
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (m_idle[k]) begin
          for (int off = 0; off < N; off++) begin
            i = (m_ptr[k] + off) % N;
            if (req_v[k][i]) begin
              m_idle[k] = 1'b0;
              m_g[k]    = cyc;
              m_id[k]   = i;
              m_byte[k] = data_v[k][8*i +: 8];
              break;
            end
          end
        end else begin
          t = cyc - m_g[k];
          if (t == 20*div_of(k)) m_ptr[k] = (m_id[k] + 1) % N;
          if (t == 20*div_of(k) + GAP) m_idle[k] = 1'b1;
        end
      end
    end
  end

  function automatic logic bit_of(input logic [7:0] b, input int p);
    return (p >= 1 && p <= 8) ? b[8-p] : 1'b0;
  endfunction

  always @(negedge clk) begin
    int t, d, p, r;
    logic e_cs, e_sclk, e_mosi, e_busy;
    logic [N-1:0] e_ack;
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        e_cs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0; e_ack = '0;
        if (!m_idle[k]) begin
          d = div_of(k);
          t = cyc - m_g[k];
          e_busy = 1'b1;
          if (t < 20*d) begin
            p = t / (2*d);
            r = t % (2*d);
            e_cs   = 1'b0;
            e_sclk = (r >= d);
            e_mosi = (r >= d) ? bit_of(m_byte[k], p) : ((p > 0) ? bit_of(m_byte[k], p-1) : 1'b0);
          end else if (t == 20*d) begin
            e_ack = N'(1) << m_id[k];
          end
        end
        check($sformatf("dut%0d_cs", k),        32'(cs_v[k]),   32'(e_cs));
        check($sformatf("dut%0d_sclk", k),      32'(sclk_v[k]), 32'(e_sclk));
        check($sformatf("dut%0d_mosi", k),      32'(mosi_v[k]), 32'(e_mosi));
        check($sformatf("dut%0d_busy", k),      32'(busy_v[k]), 32'(e_busy));
        check($sformatf("dut%0d_ack", k),       32'(ack_v[k]),  32'(e_ack));
        check($sformatf("dut%0d_active_id", k), 32'(id_v[k]),   32'(m_id[k]));
      end
    end
  end

  // Observes one frame: cs-high cycles before it, bits seen at sclk falling edges, cs-low length.
  task automatic capture(input int k, input int drop_at, output logic [9:0] bits, output int lat,
                         output int low_cnt, output int hi_cnt, output int busy_lo,
                         output logic [N-1:0] ack_seen, output logic [2:0] id_seen);
    logic prev_s, prev_m;
    bit done;
    bits = '0; lat = 0; low_cnt = 0; hi_cnt = 0; busy_lo = 0; ack_seen = '0; id_seen = '0;
    done = 1'b0;
    while (lat < 200) begin
      @(negedge clk);
      if (!cs_v[k]) begin done = 1'b1; break; end
      lat++;
      if (!busy_v[k]) busy_lo++;
    end
    if (!done) begin
      fail($sformatf("dut%0d_cs_fall", k));
      return;
    end
    id_seen = id_v[k];
    prev_s = sclk_v[k];
    prev_m = mosi_v[k];
    low_cnt = 1;
    hi_cnt = sclk_v[k] ? 1 : 0;
    done = 1'b0;
    while (low_cnt < 200) begin
      @(negedge clk);
      if (prev_s && !sclk_v[k]) bits = {bits[8:0], prev_m};
      if (cs_v[k]) begin ack_seen = ack_v[k]; done = 1'b1; break; end
      low_cnt++;
      if (sclk_v[k]) hi_cnt++;
      if (low_cnt == drop_at) req_v[k] = '0;
      prev_s = sclk_v[k];
      prev_m = mosi_v[k];
    end
    if (!done) fail($sformatf("dut%0d_cs_rise", k));
  endtask

  initial begin
    logic [9:0] bits;
    int lat, low, hi, blo;
    logic [N-1:0] a;
    logic [2:0] id;
    logic [7:0] exp_b;
    bit found;

    rst_n = 1'b0;
    req_v = '0;
    data_v = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst%0d_cs", k),   32'(cs_v[k]),   32'd1);
      check($sformatf("rst%0d_sclk", k), 32'(sclk_v[k]), 32'd0);
      check($sformatf("rst%0d_mosi", k), 32'(mosi_v[k]), 32'd0);
      check($sformatf("rst%0d_ack", k),  32'(ack_v[k]),  32'd0);
      check($sformatf("rst%0d_busy", k), 32'(busy_v[k]), 32'd0);
      check($sformatf("rst%0d_id", k),   32'(id_v[k]),   32'd0);
    end
    @(negedge clk); #1 rst_n = 1'b1;

    // Single request, byte A5.
    @(posedge clk); #1;
    data_v[0] = 32'h5A3C_96A5;
    req_v[0]  = 4'b0001;
    capture(0, -1, bits, lat, low, hi, blo, a, id);
    req_v[0] = '0;
    check("single_latency", 32'(lat),  32'd1);
    check("single_bits",    32'(bits), 32'(10'b0_1010_0101_0));
    check("single_cs_low",  32'(low),  32'd40);
    check("single_sclk_hi", 32'(hi),   32'd20);
    check("single_ack",     32'(a),    32'b0001);
    check("single_id",      32'(id),   32'd0);
    repeat (10) @(negedge clk);

    // Full contention from a fresh pointer.
    rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    data_v[0] = 32'h4433_2211;
    req_v[0]  = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      capture(0, -1, bits, lat, low, hi, blo, a, id);
      exp_b = 8'(((f % 4) + 1) * 8'h11);
      check($sformatf("rr%0d_bits", f), 32'(bits), 32'({1'b0, exp_b, 1'b0}));
      check($sformatf("rr%0d_id", f),   32'(id),   32'(f % 4));
      check($sformatf("rr%0d_ack", f),  32'(a),    32'(1 << (f % 4)));
      if (f > 0) begin
        check($sformatf("rr%0d_cs_high", f),  32'(lat + 1), 32'd5);
        check($sformatf("rr%0d_busy_low", f), 32'(blo),     32'd1);
      end
      if (f == 4) req_v[0] = '0;
    end
    repeat (10) @(negedge clk);

    // Reset mid-frame while data bit 3 is on the wire; pointer was left at 1.
    data_v[0] = 32'h00FF_00C3;
    req_v[0]  = 4'b0101;
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!cs_v[0]) begin found = 1'b1; break; end
    end
    if (!found) fail("abort_cs_fall");
    repeat (22) @(posedge clk);
    #2;
    check("abort_pre_sclk", 32'(sclk_v[0]), 32'd1);
    check("abort_pre_mosi", 32'(mosi_v[0]), 32'd1);
    check("abort_pre_id",   32'(id_v[0]),   32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_cs",   32'(cs_v[0]),   32'd1);
    check("abort_sclk", 32'(sclk_v[0]), 32'd0);
    check("abort_mosi", 32'(mosi_v[0]), 32'd0);
    check("abort_ack",  32'(ack_v[0]),  32'd0);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    capture(0, -1, bits, lat, low, hi, blo, a, id);
    check("after_rst_id",   32'(id),   32'd0);
    check("after_rst_bits", 32'(bits), 32'(10'b0_1100_0011_0));
    check("after_rst_ack",  32'(a),    32'b0001);
    req_v[0] = 4'b0100;
    capture(0, -1, bits, lat, low, hi, blo, a, id);
    req_v[0] = '0;
    check("req2_id",   32'(id),   32'd2);
    check("req2_bits", 32'(bits), 32'(10'b0_1111_1111_0));
    check("req2_ack",  32'(a),    32'b0100);
    repeat (10) @(negedge clk);

    // Request withdrawn mid-frame on the CLK_DIV=1 instance.
    @(posedge clk); #1;
    data_v[1] = 32'h0000_3C00;
    req_v[1]  = 4'b0010;
    capture(1, 7, bits, lat, low, hi, blo, a, id);
    check("wd_req_dropped", 32'(req_v[1]), 32'd0);
    check("wd_cs_low",  32'(low),  32'd20);
    check("wd_sclk_hi", 32'(hi),   32'd10);
    check("wd_ack",     32'(a),    32'b0010);
    check("wd_id",      32'(id),   32'd1);
    check("wd_bits",    32'(bits), 32'(10'b0_0011_1100_0));
    repeat (10) @(negedge clk);

    // Random traffic: requesters hold until ack, occasionally withdraw; data churns freely.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < N; i++) begin
          if (ack_v[k][i]) req_v[k][i] = 1'b0;
          else if (!req_v[k][i] && ($urandom % 4 == 0)) req_v[k][i] = 1'b1;
          else if (req_v[k][i] && ($urandom % 128 == 0)) req_v[k][i] = 1'b0;
        end
        data_v[k] = $urandom;
      end
    end
    req_v = '0;
    repeat (80) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
